// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - state encoding and default widths for operand entry
package operand_entry_pkg;

   localparam int FIELD_W_DEFAULT = 5;

   typedef enum logic [1:0] {
      EDIT_A = 2'd0,
      EDIT_B = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, hold-time debounce and rising-edge press strobe
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // Any cycle where s2 agrees with db drops the count back to zero
   always_comb begin
      s1_d    = raw_i;
      s2_d    = s1_q;
      db_d    = db_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d    = s2_q;
            press_d = s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - pushbutton editor producing the packed {A, B} operand word
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIELD_W         = FIELD_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 btn_next,
   input  logic                 btn_clear,
   output logic [2*FIELD_W-1:0] operand,
   output logic                 field,
   output logic                 done,
   output logic                 done_pulse
);

   logic up_press, down_press, next_press, clear_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .reset(reset), .raw_i(btn_up), .press_o(up_press)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .reset(reset), .raw_i(btn_down), .press_o(down_press)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk(clk), .reset(reset), .raw_i(btn_next), .press_o(next_press)
   );
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk(clk), .reset(reset), .raw_i(btn_clear), .press_o(clear_press)
   );

   state_t               state_q, state_d;
   logic [2*FIELD_W-1:0] operand_q, operand_d;
   logic                 done_pulse_q, done_pulse_d;
   logic [FIELD_W-1:0]   sel_val, new_val;

   // Priority clear > next > up/down; losers in the same cycle are dropped
   always_comb begin
      state_d      = state_q;
      operand_d    = operand_q;
      done_pulse_d = 1'b0;
      sel_val      = (state_q == EDIT_B) ? operand_q[FIELD_W-1:0]
                                         : operand_q[2*FIELD_W-1:FIELD_W];
      new_val      = up_press ? sel_val + FIELD_W'(1) : sel_val - FIELD_W'(1);
      if (clear_press) begin
         state_d   = EDIT_A;
         operand_d = '0;
      end else if (next_press) begin
         case (state_q)
            EDIT_A:  state_d = EDIT_B;
            EDIT_B: begin
               state_d      = DONE;
               done_pulse_d = 1'b1;
            end
            DONE:    state_d = EDIT_A;
            default: state_d = EDIT_A;
         endcase
      end else if ((state_q != DONE) && (up_press ^ down_press)) begin
         if (state_q == EDIT_B) begin
            operand_d[FIELD_W-1:0] = new_val;
         end else begin
            operand_d[2*FIELD_W-1:FIELD_W] = new_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EDIT_A;
         operand_q    <= '0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         operand_q    <= operand_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   assign operand    = operand_q;
   assign field      = (state_q == EDIT_B);
   assign done       = (state_q == DONE);
   assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - directed and randomized bench with a behavioural reference model
module tb_operand_entry;

   localparam int DC = 4;
   localparam int W  = 5;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [3:0]     btn = 4'b0;
   logic [2*W-1:0] operand;
   logic           field, done, done_pulse;

   int checks = 0;
   int errors = 0;
   int dp_cnt = 0;

   operand_entry #(.DEBOUNCE_CYCLES(DC), .FIELD_W(W)) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn[0]), .btn_down(btn[1]), .btn_next(btn[2]), .btn_clear(btn[3]),
      .operand(operand), .field(field), .done(done), .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   // Reference model: a button is accepted once its synchronised level has
   // disagreed with the accepted level for DC samples in a row.
   int  m_a, m_b, m_stage, m_dp;
   bit  m_s1[4], m_s2[4], m_db[4], m_pend[4];
   bit  hist[4][$];

   task automatic model_step();
      bit newp[4];
      bit all;
      m_dp = 0;
      if (reset) begin
         m_a = 0; m_b = 0; m_stage = 0;
         for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_pend[i] = 0;
            hist[i].delete();
         end
         return;
      end
      if (m_pend[3]) begin
         m_stage = 0; m_a = 0; m_b = 0;
      end else if (m_pend[2]) begin
         if (m_stage == 1) m_dp = 1;
         m_stage = (m_stage + 1) % 3;
      end else if (m_stage != 2 && (m_pend[0] != m_pend[1])) begin
         int delta = m_pend[0] ? 1 : 31;
         if (m_stage == 1) m_b = (m_b + delta) % 32;
         else              m_a = (m_a + delta) % 32;
      end
      for (int i = 0; i < 4; i++) begin
         hist[i].push_back(m_s2[i]);
         if (hist[i].size() > DC) void'(hist[i].pop_front());
         all = (hist[i].size() == DC);
         foreach (hist[i][k]) if (hist[i][k] == m_db[i]) all = 0;
         newp[i] = all && m_s2[i];
         if (all) m_db[i] = m_s2[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = btn[i];
      end
      for (int i = 0; i < 4; i++) m_pend[i] = newp[i];
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (done_pulse) dp_cnt++;
      check("model_operand", 32'(operand), 32'(m_a * 32 + m_b));
      check("model_field", 32'(field), 32'(m_stage == 1));
      check("model_done", 32'(done), 32'(m_stage == 2));
      check("model_done_pulse", 32'(done_pulse), 32'(m_dp));
   endtask

   task automatic push(input logic [3:0] m);
      btn = m;
      repeat (DC + 3) tick();
      btn = 4'b0;
      repeat (DC + 3) tick();
   endtask

   initial begin
      reset = 1'b1;
      btn   = 4'b0;
      repeat (3) tick();
      check("reset_operand", 32'(operand), 0);
      check("reset_field", 32'(field), 0);
      check("reset_done", 32'(done), 0);
      check("reset_done_pulse", 32'(done_pulse), 0);
      reset = 1'b0;
      tick();

      // Up held 10 cycles: press at 6th edge, operand updates at 7th
      btn = 4'b0001;
      repeat (DC + 2) tick();
      check("latency_before", 32'(operand), 32'h000);
      tick();
      check("latency_after", 32'(operand), 32'h020);
      repeat (3) tick();
      btn = 4'b0;
      repeat (8) tick();
      check("hold_single_press", 32'(operand), 32'h020);
      check("hold_field", 32'(field), 0);

      // Glitches of 3 cycles high must be rejected
      repeat (4) begin
         btn = 4'b0001;
         repeat (3) tick();
         btn = 4'b0;
         tick();
      end
      repeat (8) tick();
      check("glitch_reject", 32'(operand), 32'h020);

      push(4'b1000);
      check("clear_to_zero", 32'(operand), 32'h000);
      push(4'b0010);
      check("down_wrap", 32'(operand), 32'h3E0);
      push(4'b0100);
      push(4'b0001);
      push(4'b0001);
      check("edit_b", 32'(operand), 32'h3E2);
      check("edit_b_field", 32'(field), 1);

      dp_cnt = 0;
      push(4'b0100);
      check("done_pulse_once", 32'(dp_cnt), 1);
      check("done_level", 32'(done), 1);
      push(4'b0001);
      check("up_ignored_in_done", 32'(operand), 32'h3E2);
      push(4'b0100);
      check("done_exit", 32'(done), 0);
      check("done_exit_field", 32'(field), 0);
      check("operand_retained", 32'(operand), 32'h3E2);

      push(4'b0100);
      dp_cnt = 0;
      push(4'b1100);
      check("clear_beats_next", 32'(operand), 32'h000);
      check("clear_beats_next_field", 32'(field), 0);
      check("clear_no_pulse", 32'(dp_cnt), 0);

      repeat (5) push(4'b0001);
      check("a_is_5", 32'(operand), 32'h0A0);
      btn = 4'b0001;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("reset_mid_op", 32'(operand), 32'h000);
      reset = 1'b0;
      repeat (DC + 2) tick();
      check("requalify_before", 32'(operand), 32'h000);
      tick();
      check("requalify_after", 32'(operand), 32'h020);
      btn = 4'b0;
      repeat (8) tick();

      for (int it = 0; it < 200; it++) begin
         btn = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 40) == 0) reset = 1'b1;
         repeat ($urandom_range(1, 9)) begin
            tick();
            reset = 1'b0;
         end
         btn = 4'b0;
         repeat ($urandom_range(1, 9)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- User-input front end for the two-operand datapath, on the input side of the display path.
- Turns raw pushbutton presses into a 10-bit operand word. Operand A is in [9:5] and operand B is in [4:0], the same packing the display-side blocks consume from the DIP switches.
- Synchronises and debounces every button, then runs a small editing FSM. Replaces hand-set DIP switches with stepped, validated entry.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must hold a new level before it is accepted (≥2).
- FIELD_W, 5: width of each operand.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- btn_up  in  1  raw async button, increment current field
- btn_down  in  1  raw async button, decrement current field
- btn_next  in  1  raw async button, advance field / confirm
- btn_clear  in  1  raw async button, zero both operands, return to A
- operand  out  2*FIELD_W  {A, B}, registered
- field  out  1  0 = editing A, 1 = editing B (valid in EDIT states)
- done  out  1  level, high while in DONE
- done_pulse  out  1  one-cycle strobe on entry to DONE

Behaviour:
- Reset values: operand=0, field=0, done=0, done_pulse=0, state=EDIT_A. All sync flops, debounced levels and counters are 0.
- Per button, synchroniser and debounce:
  - Two-flop synchroniser gives s2.
  - If s2 != debounced level db, the counter increments. If they match, the counter is 0.
  - At the edge where counter==DEBOUNCE_CYCLES-1 and s2 != db still holds: db<=s2 and counter<=0.
  - press is registered and high for exactly one cycle when db goes 0→1. Release (1→0) produces no press.
- Latency: raw held high from the first sampling edge E gives press high in the cycle after edge E+DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)th edge.
- Any return of s2 to db before the count completes restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- FSM states: EDIT_A, EDIT_B, DONE. Press events are evaluated in priority order per cycle:
  1. clear_press: any state → EDIT_A, operand<=0, done<=0.
  2. next_press: EDIT_A→EDIT_B; EDIT_B→DONE with done_pulse<=1; DONE→EDIT_A with operands retained.
  3. up/down: only in EDIT_A/EDIT_B, applied to the active field.
     - up: +1 mod 2^FIELD_W (31→0).
     - down: −1 mod 2^FIELD_W (0→31).
     - up and down in the same cycle: no change.
     - Ignored in DONE.
- A lower-priority press in the same cycle as a higher-priority one is discarded, not deferred.
- Edits take effect on operand the cycle after the press cycle.
- field = (state==EDIT_B). done = (state==DONE).
- Reset mid-operation is synchronous and overrides all events that cycle. A button held through reset is re-qualified from db=0 and yields a press DEBOUNCE_CYCLES+2 edges after reset deasserts.
- Holding a button generates exactly one press; there is no auto-repeat.

Decomposition:
- Package operand_entry_pkg holds the state encoding (EDIT_A=0, EDIT_B=1, DONE=2, 2 bits) and FIELD_W default.
- Sub-module button_debounce (synchroniser + counter + press edge) is instantiated 4×.
- Counter width is $clog2(DEBOUNCE_CYCLES).

Test Plan:
- DEBOUNCE_CYCLES=4. Release reset, hold btn_up 10 cycles → exactly one press, 6 edges after the first high sample. operand goes 0x000→0x020 (A=1). field=0.
- Toggle btn_up with 3-cycle high pulses separated by 1-cycle lows → no press, operand unchanged.
- In EDIT_A with A=0, press down → A=31 (operand=0x3E0). Then press next and up ×2 → B=2, operand=0x3E2, field=1.
- In EDIT_B, press next → done_pulse high 1 cycle and done=1. Up while done=1 → operand unchanged. Next → EDIT_A, done=0, operand still 0x3E2.
- Make clear and next presses coincide in EDIT_B → EDIT_A, operand=0x000, done_pulse stays 0.
- Assert reset while btn_up is held and A=5 → operand=0 the next cycle. After deassert, one press at the 6th edge gives A=1.
